// File: rtl/half_adder_pkg.sv
// Shared state encoding for the half-adder sequencing FSM.
// st records the class (0, 1 or 2) of the most recently sampled a+b.
package half_adder_pkg;

    localparam int ST_W = 2;

    typedef logic [ST_W-1:0] st_t;

    localparam st_t S_ZERO = 2'd0;
    localparam st_t S_ONE  = 2'd1;
    localparam st_t S_TWO  = 2'd2;

    // Maps an input pair to the state naming its arithmetic class.
    function automatic st_t class_of(input logic a, input logic b);
        st_t c;
        case ({a, b})
            2'b00:   c = S_ZERO;
            2'b01,
            2'b10:   c = S_ONE;
            2'b11:   c = S_TWO;
            default: c = S_ZERO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/half_adder_fsm.sv
// One-bit half adder with Mealy outputs; st tracks the class of the
// last addition sampled on a rising edge and is otherwise unobserved.
module half_adder_fsm
    import half_adder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    st_t st;
    st_t st_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= S_ZERO;
        end else begin
            st <= st_nxt;
        end
    end

    // Every state, including the unused encoding 2'd3, moves to the class
    // of the current inputs, so an illegal state lasts at most one cycle.
    always_comb begin
        st_nxt = S_ZERO;
        case (st)
            S_ZERO:  st_nxt = class_of(a, b);
            S_ONE:   st_nxt = class_of(a, b);
            S_TWO:   st_nxt = class_of(a, b);
            default: st_nxt = class_of(a, b);
        endcase
    end

    // Outputs depend only on the inputs; reset and state never gate them.
    always_comb begin
        sum   = a ^ b;
        carry = a & b;
    end

endmodule

// File: tb/tb_half_adder_fsm.sv
// Randomized and directed checks of half_adder_fsm against an arithmetic
// reference: {carry,sum} must equal a+b and st must hold the sampled class.
module tb_half_adder_fsm;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic sum;
    logic carry;

    int checks;
    int errors;

    half_adder_fsm dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] ref_add(input logic x, input logic y);
        int s;
        s = int'(x) + int'(y);
        return s[1:0];
    endfunction

    function automatic logic [1:0] ref_state(input logic r, input logic x, input logic y);
        int s;
        s = r ? 0 : int'(x) + int'(y);
        return s[1:0];
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (dut.st !== 2'd0) begin
            errors++;
            $display("FAIL reset_st got %0d want 0", dut.st);
        end
        checks++;
        if ({carry, sum} !== 2'b00) begin
            errors++;
            $display("FAIL reset_out got %b want 00", {carry, sum});
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] ab;
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            @(negedge clk);
            rst = 1'b0;
            a   = ab[1];
            b   = ab[0];
            #1;
            checks++;
            if ({carry, sum} !== ref_add(a, b)) begin
                errors++;
                $display("FAIL truth_out ab=%b got %b want %b", ab, {carry, sum}, ref_add(a, b));
            end
            @(posedge clk);
            #1;
            checks++;
            if (dut.st !== ref_state(1'b0, a, b)) begin
                errors++;
                $display("FAIL truth_st ab=%b got %0d want %0d", ab, dut.st, ref_state(1'b0, a, b));
            end
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b1;
        #1;
        checks++;
        if ({carry, sum} !== 2'b10) begin
            errors++;
            $display("FAIL rstprio_out_before got %b want 10", {carry, sum});
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut.st !== 2'd0) begin
            errors++;
            $display("FAIL rstprio_st got %0d want 0", dut.st);
        end
        checks++;
        if ({carry, sum} !== 2'b10) begin
            errors++;
            $display("FAIL rstprio_out_after got %b want 10", {carry, sum});
        end
    endtask

    // rst flips every 10 units while inputs step every 20 units.
    task automatic test_rst_toggle();
        logic [1:0] ab;
        logic       r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                r   = ~r;
                rst = r;
                a   = ab[1];
                b   = ab[0];
                #1;
                checks++;
                if ({carry, sum} !== ref_add(a, b)) begin
                    errors++;
                    $display("FAIL toggle_out ab=%b rst=%b got %b want %b", ab, rst, {carry, sum}, ref_add(a, b));
                end
                @(posedge clk);
                #1;
                checks++;
                if (dut.st !== ref_state(r, a, b)) begin
                    errors++;
                    $display("FAIL toggle_st ab=%b rst=%b got %0d want %0d", ab, r, dut.st, ref_state(r, a, b));
                end
            end
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        rst = 1'b0;
        a   = 1'b0;
        b   = 1'b1;
        force dut.st = 2'd3;
        #1;
        checks++;
        if ({carry, sum} !== 2'b01) begin
            errors++;
            $display("FAIL illegal_out got %b want 01", {carry, sum});
        end
        release dut.st;
        @(posedge clk);
        #1;
        checks++;
        if (dut.st !== 2'd1) begin
            errors++;
            $display("FAIL illegal_recover got %0d want 1", dut.st);
        end
    endtask

    // Inputs change twice per cycle; st must capture only the edge value.
    task automatic test_random();
        logic       r;
        logic [1:0] exp_st;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r   = ($urandom_range(0, 3) == 0);
            rst = r;
            a   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({carry, sum} !== ref_add(a, b)) begin
                errors++;
                $display("FAIL rand_out1 i=%0d a=%b b=%b got %b want %b", i, a, b, {carry, sum}, ref_add(a, b));
            end
            #2;
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({carry, sum} !== ref_add(a, b)) begin
                errors++;
                $display("FAIL rand_out2 i=%0d a=%b b=%b got %b want %b", i, a, b, {carry, sum}, ref_add(a, b));
            end
            exp_st = ref_state(r, a, b);
            @(posedge clk);
            #1;
            checks++;
            if (dut.st !== exp_st) begin
                errors++;
                $display("FAIL rand_st i=%0d got %0d want %0d", i, dut.st, exp_st);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        a      = 1'b0;
        b      = 1'b0;
        test_reset();
        test_truth_table();
        test_reset_priority();
        test_rst_toggle();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
